// File: rtl/dbg_run_ctrl_if.sv
// Command channel between the JTAG debug command source and the run controller.
// The source drives valid/op/arg and holds them until the controller raises ready.
interface dbg_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Debug run controller: turns run/halt/step/reset commands from the JTAG test
// logic into a registered core clock enable and an active-high debug reset,
// and counts the core cycles that were enabled.
//
// Optional feature macro: DBG_BREAKPOINT_EN
//   defined   - single PC breakpoint that halts the core from RUN (bp_hit sticky)
//   undefined - pc/bp_wr/bp_addr are ignored and bp_hit is tied low
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | core clocked freely, RUN/HALT/STEP/RESET accepted
// S_HALTED | core clock gated off, RUN/HALT/STEP/RESET accepted
// S_STEP   | core clocked for cnt_q more cycles, only HALT accepted
// S_RST    | dm_reset asserted with clock running for cnt_q+1 cycles, no cmds
module dbg_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter bit RESET_HALT = 1'b0
) (
  input  logic           sysclk,
  input  logic           sys_reset_n,
  dbg_run_ctrl_if.slave  cmd,
  output logic           dbg_clk_en,
  output logic           dm_reset,
  output logic           halted,
  output logic           step_done,
  output logic [31:0]    cycle_cnt,
  input  logic [31:0]    pc,
  input  logic           bp_wr,
  input  logic [31:0]    bp_addr,
  output logic           bp_hit
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2,
    S_RST    = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_HALT  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam state_t RST_STATE = RESET_HALT ? S_HALTED : S_RUN;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ret_halt_q, ret_halt_d;
  logic             step_done_d;
  logic             accept;
  logic             bp_match;
  logic             bp_fire;

  assign accept = cmd.cmd_valid & cmd.cmd_ready;
  assign halted = (state_q == S_HALTED);

  // Which commands can be taken in the current state
  always_comb begin
    cmd.cmd_ready = 1'b0;
    case (state_q)
      S_RUN, S_HALTED: cmd.cmd_ready = 1'b1;
      S_STEP:          cmd.cmd_ready = (cmd.cmd_op == OP_HALT);
      default:         cmd.cmd_ready = 1'b0;
    endcase
  end

  // Next-state decode; an accepted command always takes priority over a breakpoint
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_halt_d  = ret_halt_q;
    step_done_d = 1'b0;
    bp_fire     = 1'b0;
    case (state_q)
      S_RUN, S_HALTED: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RUN:  state_d = S_RUN;
            OP_HALT: state_d = S_HALTED;
            OP_STEP: begin
              if (cmd.cmd_arg == '0) begin
                state_d     = S_HALTED;
                step_done_d = 1'b1;
              end else begin
                state_d = S_STEP;
                cnt_d   = cmd.cmd_arg;
              end
            end
            default: begin
              state_d    = S_RST;
              cnt_d      = cmd.cmd_arg;
              ret_halt_d = (state_q == S_HALTED);
            end
          endcase
        end else if (state_q == S_RUN && bp_match) begin
          state_d = S_HALTED;
          bp_fire = 1'b1;
        end
      end
      S_STEP: begin
        // cnt_q is never zero here: a zero-length step skips this state
        if (accept) begin
          state_d = S_HALTED;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d     = S_HALTED;
          step_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = ret_halt_q ? S_HALTED : S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // State, timer and registered core controls
  always_ff @(posedge sysclk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      ret_halt_q <= 1'b0;
      dbg_clk_en <= !RESET_HALT;
      dm_reset   <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ret_halt_q <= ret_halt_d;
      dbg_clk_en <= (state_d != S_HALTED);
      dm_reset   <= (state_d == S_RST);
      step_done  <= step_done_d;
    end
  end

  // Enabled core cycle counter, free-wrapping
  always_ff @(posedge sysclk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cycle_cnt <= '0;
    end else if (dbg_clk_en) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

`ifdef DBG_BREAKPOINT_EN
  logic        bp_armed_q;
  logic [31:0] bp_addr_q;

  assign bp_match = bp_armed_q && (pc == bp_addr_q) && dbg_clk_en;

  // Breakpoint register; a new write re-arms and clears the sticky hit flag
  always_ff @(posedge sysclk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      bp_armed_q <= 1'b0;
      bp_addr_q  <= '0;
      bp_hit     <= 1'b0;
    end else if (bp_wr) begin
      bp_armed_q <= 1'b1;
      bp_addr_q  <= bp_addr;
      bp_hit     <= 1'b0;
    end else if (bp_fire) begin
      bp_armed_q <= 1'b0;
      bp_hit     <= 1'b1;
    end
  end
`else
  wire unused_bp = ^{pc, bp_wr, bp_addr, bp_fire};

  assign bp_match = 1'b0;
  assign bp_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl (RESET_HALT=0). Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_dbg_run_ctrl;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_HALT  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  logic        sysclk;
  logic        sys_reset_n;
  logic        dbg_clk_en;
  logic        dm_reset;
  logic        halted;
  logic        step_done;
  logic [31:0] cycle_cnt;
  logic [31:0] pc;
  logic        bp_wr;
  logic [31:0] bp_addr;
  logic        bp_hit;

  int checks   = 0;
  int failures = 0;

  dbg_run_ctrl_if #(.CNT_W(16)) cmd_if ();

  dbg_run_ctrl #(.CNT_W(16), .RESET_HALT(1'b0)) dut (
    .sysclk      (sysclk),
    .sys_reset_n (sys_reset_n),
    .cmd         (cmd_if),
    .dbg_clk_en  (dbg_clk_en),
    .dm_reset    (dm_reset),
    .halted      (halted),
    .step_done   (step_done),
    .cycle_cnt   (cycle_cnt),
    .pc          (pc),
    .bp_wr       (bp_wr),
    .bp_addr     (bp_addr),
    .bp_hit      (bp_hit)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Present one command at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    @(posedge sysclk);
    @(negedge sysclk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_reset_n      = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_RUN;
    cmd_if.cmd_arg   = '0;
    pc = '0; bp_wr = 1'b0; bp_addr = '0;
    repeat (2) @(negedge sysclk);
    checks++; if (dbg_clk_en !== 1'b1) begin failures++; $display("FAIL rst_clk_en got=%b exp=1", dbg_clk_en); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (dm_reset !== 1'b0) begin failures++; $display("FAIL rst_dm_reset got=%b exp=0", dm_reset); end
    checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL rst_step_done got=%b exp=0", step_done); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL rst_cycle_cnt got=%0d exp=0", cycle_cnt); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL rst_bp_hit got=%b exp=0", bp_hit); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_if.cmd_ready); end
    sys_reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge sysclk);
      checks++; if (cycle_cnt !== 32'(i)) begin failures++; $display("FAIL run_count got=%0d exp=%0d", cycle_cnt, i); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    c0 = cycle_cnt;
    issue(OP_HALT, 16'd0);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
    checks++; if (dbg_clk_en !== 1'b0) begin failures++; $display("FAIL halt_clk_en got=%b exp=0", dbg_clk_en); end
    checks++; if (cycle_cnt !== c0 + 32'd1) begin failures++; $display("FAIL halt_count got=%0d exp=%0d", cycle_cnt, c0 + 32'd1); end
    repeat (3) @(negedge sysclk);
    issue(OP_HALT, 16'd0);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_noop got=%b exp=1", halted); end
    checks++; if (cycle_cnt !== c0 + 32'd1) begin failures++; $display("FAIL halt_frozen got=%0d exp=%0d", cycle_cnt, c0 + 32'd1); end
  endtask

  task automatic test_step5();
    logic [31:0] c0;
    c0 = cycle_cnt;
    issue(OP_STEP, 16'd5);
    for (int n = 1; n <= 7; n++) begin
      if (n > 1) @(negedge sysclk);
      checks++; if (dbg_clk_en !== (n <= 5)) begin failures++; $display("FAIL step5_clk_en n=%0d got=%b exp=%b", n, dbg_clk_en, (n <= 5)); end
      checks++; if (step_done !== (n == 6)) begin failures++; $display("FAIL step5_done n=%0d got=%b exp=%b", n, step_done, (n == 6)); end
      if (n == 1) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_RUN;
        #1;
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL step5_ready_run got=%b exp=0", cmd_if.cmd_ready); end
      end
      if (n == 3) cmd_if.cmd_valid = 1'b0;
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL step5_halted got=%b exp=1", halted); end
    checks++; if (cycle_cnt !== c0 + 32'd5) begin failures++; $display("FAIL step5_count got=%0d exp=%0d", cycle_cnt, c0 + 32'd5); end
  endtask

  task automatic test_step0();
    logic [31:0] c0;
    c0 = cycle_cnt;
    issue(OP_STEP, 16'd0);
    checks++; if (step_done !== 1'b1) begin failures++; $display("FAIL step0_done got=%b exp=1", step_done); end
    checks++; if (dbg_clk_en !== 1'b0) begin failures++; $display("FAIL step0_clk_en got=%b exp=0", dbg_clk_en); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL step0_halted got=%b exp=1", halted); end
    @(negedge sysclk);
    checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL step0_pulse got=%b exp=0", step_done); end
    checks++; if (cycle_cnt !== c0) begin failures++; $display("FAIL step0_count got=%0d exp=%0d", cycle_cnt, c0); end
  endtask

  task automatic test_step_abort();
    logic [31:0] c0;
    c0 = cycle_cnt;
    issue(OP_STEP, 16'd100);
    repeat (9) @(negedge sysclk);
    checks++; if (dbg_clk_en !== 1'b1) begin failures++; $display("FAIL abort_clk_en10 got=%b exp=1", dbg_clk_en); end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_HALT;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", cmd_if.cmd_ready); end
    @(posedge sysclk);
    @(negedge sysclk);
    cmd_if.cmd_valid = 1'b0;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL abort_halted got=%b exp=1", halted); end
    checks++; if (dbg_clk_en !== 1'b0) begin failures++; $display("FAIL abort_clk_en got=%b exp=0", dbg_clk_en); end
    checks++; if (cycle_cnt !== c0 + 32'd10) begin failures++; $display("FAIL abort_count got=%0d exp=%0d", cycle_cnt, c0 + 32'd10); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL abort_no_done i=%0d got=%b exp=0", i, step_done); end
      @(negedge sysclk);
    end
  endtask

  task automatic test_rst_cmd();
    logic [31:0] c0;
    c0 = cycle_cnt;
    issue(OP_RESET, 16'd3);
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) @(negedge sysclk);
      checks++; if (dm_reset !== 1'b1) begin failures++; $display("FAIL rst3_dm_reset n=%0d got=%b exp=1", n, dm_reset); end
      checks++; if (dbg_clk_en !== 1'b1) begin failures++; $display("FAIL rst3_clk_en n=%0d got=%b exp=1", n, dbg_clk_en); end
      checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst3_ready n=%0d got=%b exp=0", n, cmd_if.cmd_ready); end
    end
    @(negedge sysclk);
    checks++; if (dm_reset !== 1'b0) begin failures++; $display("FAIL rst3_release got=%b exp=0", dm_reset); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rst3_halted got=%b exp=1", halted); end
    checks++; if (dbg_clk_en !== 1'b0) begin failures++; $display("FAIL rst3_clk_off got=%b exp=0", dbg_clk_en); end
    checks++; if (cycle_cnt !== c0 + 32'd4) begin failures++; $display("FAIL rst3_count got=%0d exp=%0d", cycle_cnt, c0 + 32'd4); end
  endtask

  task automatic test_run_reset();
    issue(OP_RUN, 16'd0);
    checks++; if (halted !== 1'b0 || dbg_clk_en !== 1'b1) begin failures++; $display("FAIL run_resume got=%b%b exp=01", halted, dbg_clk_en); end
    issue(OP_RUN, 16'd0);
    checks++; if (halted !== 1'b0 || dbg_clk_en !== 1'b1) begin failures++; $display("FAIL run_noop got=%b%b exp=01", halted, dbg_clk_en); end
    issue(OP_RESET, 16'd0);
    checks++; if (dm_reset !== 1'b1) begin failures++; $display("FAIL rst0_dm_reset got=%b exp=1", dm_reset); end
    @(negedge sysclk);
    checks++; if (dm_reset !== 1'b0) begin failures++; $display("FAIL rst0_release got=%b exp=0", dm_reset); end
    checks++; if (halted !== 1'b0 || dbg_clk_en !== 1'b1) begin failures++; $display("FAIL rst0_back_run got=%b%b exp=01", halted, dbg_clk_en); end
  endtask

  task automatic test_breakpoint();
    pc = 32'h0; bp_addr = 32'h40; bp_wr = 1'b1;
    @(negedge sysclk);
    bp_wr = 1'b0;
    checks++; if (halted !== 1'b0 || bp_hit !== 1'b0) begin failures++; $display("FAIL bp_armed got=%b%b exp=00", halted, bp_hit); end
    pc = 32'h40;
    @(negedge sysclk);
`ifdef DBG_BREAKPOINT_EN
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bp_halted got=%b exp=1", halted); end
    checks++; if (dbg_clk_en !== 1'b0) begin failures++; $display("FAIL bp_clk_en got=%b exp=0", dbg_clk_en); end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit got=%b exp=1", bp_hit); end
    issue(OP_RUN, 16'd0);
    @(negedge sysclk);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL bp_disarmed got=%b exp=0", halted); end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%b exp=1", bp_hit); end
    pc = 32'h0; bp_addr = 32'h80; bp_wr = 1'b1;
    @(negedge sysclk);
    bp_wr = 1'b0;
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", bp_hit); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (halted !== 1'b0 || dbg_clk_en !== 1'b1 || bp_hit !== 1'b0) begin failures++; $display("FAIL bp_ignored i=%0d got=%b%b%b exp=010", i, halted, dbg_clk_en, bp_hit); end
      @(negedge sysclk);
    end
    pc = 32'h0;
`endif
  endtask

  task automatic test_async_reset();
    issue(OP_HALT, 16'd0);
    issue(OP_STEP, 16'd50);
    repeat (3) @(negedge sysclk);
    #2 sys_reset_n = 1'b0;
    #1;
    checks++; if (dbg_clk_en !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL arst_state got=%b%b exp=10", dbg_clk_en, halted); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", cycle_cnt); end
    @(negedge sysclk);
    sys_reset_n = 1'b1;
    @(negedge sysclk);
    checks++; if (cycle_cnt !== 32'd1 || halted !== 1'b0 || step_done !== 1'b0) begin failures++; $display("FAIL arst_resume got=%0d/%b/%b exp=1/0/0", cycle_cnt, halted, step_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_halt();
    test_step5();
    test_step0();
    test_step_abort();
    test_rst_cmd();
    test_run_reset();
    test_breakpoint();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
